// File: rtl/mean_removal_multichannel.sv
// Time-multiplexed per-channel sliding-window DC remover: bypass, mean-removed or mean output.
// Three-stage pipeline (memory/pointer, accumulate, shift/saturate) accepting one sample per clock.
module mean_removal_multichannel #(
  parameter int W               = 24,
  parameter int CH              = 8,
  parameter int LOG2_M          = 5,
  parameter int SUPPRESS_WARMUP = 0,
  parameter int CW              = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [1:0]           mode,
  input  logic signed [W-1:0]  data_in,
  input  logic [CW-1:0]        data_in_channel,
  input  logic                 data_in_valid,
  output logic signed [W-1:0]  data_out,
  output logic [CW-1:0]        data_out_channel,
  output logic                 data_out_valid,
  output logic                 window_full
);

  localparam int M     = 1 << LOG2_M;
  localparam int ACC   = W + LOG2_M;
  localparam int FW    = LOG2_M + 1;
  localparam int AW    = CW + LOG2_M;
  localparam int DEPTH = CH * M;
  localparam logic [FW-1:0] FILL_MAX    = FW'(M);
  localparam logic [FW-1:0] FILL_ALMOST = FW'(M - 1);
  localparam logic [1:0] MODE_REMOVE = 2'b01;
  localparam logic [1:0] MODE_MEAN   = 2'b10;

  logic signed [W-1:0] mem [DEPTH];

  logic [CH*LOG2_M-1:0] ptr_flat;
  logic [CH*FW-1:0]     fill_flat;
  logic [CH*ACC-1:0]    acc_flat;

  logic                channel_in_range;
  logic                in_accept;
  logic [LOG2_M-1:0]   in_ptr;
  logic [FW-1:0]       in_fill;
  logic [AW-1:0]       mem_addr;

  logic                s1_valid_reg;
  logic signed [W-1:0] s1_sample_reg;
  logic signed [W-1:0] s1_old_reg;
  logic [CW-1:0]       s1_channel_reg;
  logic [1:0]          s1_mode_reg;
  logic                s1_full_reg;
  logic                s1_window_full_reg;

  logic signed [ACC-1:0] acc_cur;
  logic signed [ACC-1:0] acc_next;
  logic signed [ACC-1:0] sample_ext;
  logic signed [ACC-1:0] outgoing_ext;

  logic                s2_valid_reg;
  logic signed [W-1:0] s2_sample_reg;
  logic signed [W-1:0] s2_mean_reg;
  logic [CW-1:0]       s2_channel_reg;
  logic [1:0]          s2_mode_reg;
  logic                s2_window_full_reg;

  logic signed [W:0]   diff_next;
  logic signed [W-1:0] diff_sat_next;
  logic signed [W-1:0] result_next;
  logic                out_valid_next;

  logic signed [W-1:0] data_out_reg;
  logic [CW-1:0]       data_out_channel_reg;
  logic                data_out_valid_reg;
  logic                window_full_reg;

  // Stage 1: accept, look up this channel's pointer and fill level
  assign channel_in_range = ({1'b0, data_in_channel} < (CW+1)'(CH));
  assign in_accept        = data_in_valid & ~clear & channel_in_range;
  assign in_ptr           = ptr_flat[data_in_channel*LOG2_M +: LOG2_M];
  assign in_fill          = fill_flat[data_in_channel*FW +: FW];
  assign mem_addr         = {data_in_channel, in_ptr};

  // Read-before-write: the slot being overwritten is the sample leaving the window
  always_ff @(posedge clock) begin
    if (in_accept) begin
      s1_old_reg     <= mem[mem_addr];
      mem[mem_addr]  <= data_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_reg       <= 1'b0;
      s1_sample_reg      <= '0;
      s1_channel_reg     <= '0;
      s1_mode_reg        <= '0;
      s1_full_reg        <= 1'b0;
      s1_window_full_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_accept;
      if (in_accept) begin
        s1_sample_reg      <= data_in;
        s1_channel_reg     <= data_in_channel;
        s1_mode_reg        <= mode;
        s1_full_reg        <= (in_fill == FILL_MAX);
        s1_window_full_reg <= (in_fill >= FILL_ALMOST);
      end
    end
  end

  // Stage 2: the outgoing term is masked until the window is full, so memory never needs clearing
  assign acc_cur      = $signed(acc_flat[s1_channel_reg*ACC +: ACC]);
  assign sample_ext   = {{LOG2_M{s1_sample_reg[W-1]}}, s1_sample_reg};
  assign outgoing_ext = s1_full_reg ? {{LOG2_M{s1_old_reg[W-1]}}, s1_old_reg} : '0;
  assign acc_next     = acc_cur + sample_ext - outgoing_ext;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_chan
      logic [LOG2_M-1:0]     ptr_reg;
      logic [FW-1:0]         fill_reg;
      logic signed [ACC-1:0] acc_reg;
      logic                  in_hit;
      logic                  s1_hit;

      assign in_hit = in_accept & (data_in_channel == CW'(gi));
      assign s1_hit = s1_valid_reg & (s1_channel_reg == CW'(gi));

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          ptr_reg  <= '0;
          fill_reg <= '0;
          acc_reg  <= '0;
        end else if (clear) begin
          ptr_reg  <= '0;
          fill_reg <= '0;
          acc_reg  <= '0;
        end else begin
          if (in_hit) begin
            ptr_reg <= ptr_reg + 1'b1;
            if (fill_reg != FILL_MAX)
              fill_reg <= fill_reg + 1'b1;
          end
          if (s1_hit)
            acc_reg <= acc_next;
        end
      end

      assign ptr_flat[gi*LOG2_M +: LOG2_M] = ptr_reg;
      assign fill_flat[gi*FW +: FW]        = fill_reg;
      assign acc_flat[gi*ACC +: ACC]       = acc_reg;
    end
  endgenerate

  // Dropping the low LOG2_M bits of a two's-complement sum is the floor division by M
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid_reg       <= 1'b0;
      s2_sample_reg      <= '0;
      s2_mean_reg        <= '0;
      s2_channel_reg     <= '0;
      s2_mode_reg        <= '0;
      s2_window_full_reg <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg & ~clear;
      if (s1_valid_reg) begin
        s2_sample_reg      <= s1_sample_reg;
        s2_mean_reg        <= acc_next[ACC-1:LOG2_M];
        s2_channel_reg     <= s1_channel_reg;
        s2_mode_reg        <= s1_mode_reg;
        s2_window_full_reg <= s1_window_full_reg;
      end
    end
  end

  // Stage 3: select result, saturating the mean-removed difference back to W bits
  always_comb begin
    diff_next     = {s2_sample_reg[W-1], s2_sample_reg} - {s2_mean_reg[W-1], s2_mean_reg};
    diff_sat_next = diff_next[W-1:0];
    if (diff_next[W] != diff_next[W-1])
      diff_sat_next = diff_next[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  always_comb begin
    result_next = s2_sample_reg;
    case (s2_mode_reg)
      MODE_REMOVE: result_next = diff_sat_next;
      MODE_MEAN:   result_next = s2_mean_reg;
      default:     result_next = s2_sample_reg;
    endcase
  end

  assign out_valid_next = s2_valid_reg & ((SUPPRESS_WARMUP == 0) | s2_window_full_reg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out_reg         <= '0;
      data_out_channel_reg <= '0;
      data_out_valid_reg   <= 1'b0;
      window_full_reg      <= 1'b0;
    end else if (clear) begin
      data_out_valid_reg <= 1'b0;
    end else begin
      data_out_valid_reg <= out_valid_next;
      if (out_valid_next) begin
        data_out_reg         <= result_next;
        data_out_channel_reg <= s2_channel_reg;
        window_full_reg      <= s2_window_full_reg;
      end
    end
  end

  assign data_out         = data_out_reg;
  assign data_out_channel = data_out_channel_reg;
  assign data_out_valid   = data_out_valid_reg;
  assign window_full      = window_full_reg;

endmodule

// File: tb/tb_mean_removal_multichannel.sv
// Scoreboard bench: two instances (plain and warm-up-suppressed) share stimulus;
// a sliding-window reference model predicts each result and its arrival cycle.
module tb_mean_removal_multichannel;

  localparam int W      = 24;
  localparam int CH     = 8;
  localparam int LOG2_M = 5;
  localparam int M      = 32;
  localparam int CW     = 3;
  localparam longint SMAX = 8388607;
  localparam longint SMIN = -8388608;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                clear = 1'b0;
  logic [1:0]          mode = 2'b00;
  logic signed [W-1:0] data_in = '0;
  logic [CW-1:0]       data_in_channel = '0;
  logic                data_in_valid = 1'b0;

  logic signed [W-1:0] dout0, dout1;
  logic [CW-1:0]       dch0, dch1;
  logic                dv0, dv1, dwf0, dwf1;

  mean_removal_multichannel #(.W(W), .CH(CH), .LOG2_M(LOG2_M), .SUPPRESS_WARMUP(0)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .mode(mode), .data_in(data_in),
    .data_in_channel(data_in_channel), .data_in_valid(data_in_valid),
    .data_out(dout0), .data_out_channel(dch0), .data_out_valid(dv0), .window_full(dwf0));

  mean_removal_multichannel #(.W(W), .CH(CH), .LOG2_M(LOG2_M), .SUPPRESS_WARMUP(1)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .mode(mode), .data_in(data_in),
    .data_in_channel(data_in_channel), .data_in_valid(data_in_valid),
    .data_out(dout1), .data_out_channel(dch1), .data_out_valid(dv1), .window_full(dwf1));

  always #5 clock = ~clock;

  int cnt = 0;
  always @(posedge clock) cnt <= cnt + 1;

  typedef struct {
    longint data;
    int     ch;
    bit     wf;
    int     cyc;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint hist[CH][$];
  longint last_data[2];
  int     n_checks = 0;
  int     n_err = 0;

  function automatic longint floor_div_m(longint s);
    longint q;
    q = s / longint'(M);
    if ((s % longint'(M)) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp_w(longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic longint rand_sample();
    return longint'($urandom_range(0, 16777215)) - 8388608;
  endfunction

  task automatic chk(string name, longint got, longint want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, required %0d", name, cnt, got, want);
    end
  endtask

  task automatic model_flush();
    for (int c = 0; c < CH; c++) hist[c].delete();
  endtask

  task automatic purge_after(int limit);
    exp_t t[$];
    t = {};
    foreach (q0[i]) if (q0[i].cyc <= limit) t.push_back(q0[i]);
    q0 = t;
    t = {};
    foreach (q1[i]) if (q1[i].cyc <= limit) t.push_back(q1[i]);
    q1 = t;
  endtask

  // One clock of stimulus; a valid sample updates the model and queues the expected result
  task automatic apply(bit v, int ch, longint d, int md);
    exp_t   e;
    longint sum, mean, res;
    @(negedge clock);
    data_in_valid   = v;
    data_in_channel = CW'(ch);
    data_in         = W'(d);
    mode            = 2'(md);
    if (v) begin
      hist[ch].push_back(d);
      if (hist[ch].size() > M) void'(hist[ch].pop_front());
      sum = 0;
      for (int i = 0; i < hist[ch].size(); i++) sum += hist[ch][i];
      mean = floor_div_m(sum);
      case (md)
        1:       res = clamp_w(d - mean);
        2:       res = mean;
        default: res = d;
      endcase
      e.data = res;
      e.ch   = ch;
      e.wf   = (hist[ch].size() == M);
      e.cyc  = cnt + 3;
      q0.push_back(e);
      if (e.wf) q1.push_back(e);
    end
  endtask

  // Clear cycle also carries a sample that must be discarded
  task automatic do_clear();
    @(negedge clock);
    clear           = 1'b1;
    data_in_valid   = 1'b1;
    data_in_channel = 3'd1;
    data_in         = 24'sd12345;
    purge_after(cnt);
    model_flush();
    @(negedge clock);
    clear         = 1'b0;
    data_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    purge_after(cnt);
    model_flush();
    #1;
    chk("async_reset_valid0", longint'(dv0), 0);
    chk("async_reset_valid1", longint'(dv1), 0);
    chk("async_reset_wfull0", longint'(dwf0), 0);
    chk("async_reset_wfull1", longint'(dwf1), 0);
    data_in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic monitor(int inst, logic v, logic signed [W-1:0] d, logic [CW-1:0] c, logic wf);
    exp_t e;
    bit   have;
    if (!reset) begin
      chk($sformatf("reset_valid%0d", inst), longint'(v), 0);
      chk($sformatf("reset_wfull%0d", inst), longint'(wf), 0);
      chk($sformatf("reset_data%0d", inst), longint'(d), 0);
      last_data[inst] = 0;
      return;
    end
    if (inst == 0) begin
      while (q0.size() > 0 && q0[0].cyc < cnt) begin
        e = q0.pop_front();
        chk("missing_out0_cycle", cnt, e.cyc);
      end
      have = (q0.size() > 0);
    end else begin
      while (q1.size() > 0 && q1[0].cyc < cnt) begin
        e = q1.pop_front();
        chk("missing_out1_cycle", cnt, e.cyc);
      end
      have = (q1.size() > 0);
    end
    if (v) begin
      if (!have) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_valid%0d @cycle %0d: got data %0d ch %0d, required no output",
                 inst, cnt, longint'(d), c);
      end else begin
        if (inst == 0) e = q0.pop_front();
        else           e = q1.pop_front();
        chk($sformatf("latency%0d", inst), cnt, e.cyc);
        chk($sformatf("data%0d", inst), longint'(d), e.data);
        chk($sformatf("channel%0d", inst), longint'(c), e.ch);
        chk($sformatf("window_full%0d", inst), longint'(wf), e.wf);
      end
      last_data[inst] = d;
    end else begin
      chk($sformatf("hold_data%0d", inst), longint'(d), last_data[inst]);
    end
  endtask

  always begin
    @(posedge clock);
    #1;
    monitor(0, dv0, dout0, dch0, dwf0);
    monitor(1, dv1, dout1, dch1, dwf1);
  end

  initial begin
    last_data[0] = 0;
    last_data[1] = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Step on ch0, remove-mean mode
    for (int k = 0; k < 40; k++) apply(1, 0, 1000, 1);
    repeat (3) apply(0, 0, 0, 1);
    do_clear();

    // Round-robin constants, mean mode
    for (int r = 0; r < 34; r++)
      for (int n = 0; n < CH; n++) apply(1, n, 100 * n - 400, 2);
    do_clear();

    // Back-to-back ramp on ch3
    for (int i = 0; i < 64; i++) apply(1, 3, i, 2);

    // Saturation both ways
    for (int i = 0; i < M; i++) apply(1, 5, SMIN, 1);
    apply(1, 5, SMAX, 1);
    for (int i = 0; i < M; i++) apply(1, 6, SMAX, 1);
    apply(1, 6, SMIN, 1);

    // Clear with two samples in flight, then warm-up on the suppressed instance
    do_clear();
    for (int i = 0; i < M; i++) apply(1, 1, rand_sample(), 1);
    apply(1, 1, rand_sample(), 1);
    apply(1, 1, rand_sample(), 1);
    do_clear();
    for (int i = 0; i < M + 2; i++) apply(1, 1, rand_sample(), 0);

    // Random traffic: channels, modes, gaps, occasional extremes
    for (int i = 0; i < 300; i++) begin
      longint d;
      d = rand_sample();
      if ($urandom_range(0, 9) == 0) d = ($urandom_range(0, 1) == 1) ? SMAX : SMIN;
      apply($urandom_range(0, 3) != 0, int'($urandom_range(0, CH - 1)), d,
            int'($urandom_range(0, 3)));
      if (i == 150) do_clear();
    end

    // Sparse bypass, then reset with results in flight, then means restart from zero
    for (int i = 0; i < 40; i++)
      apply($urandom_range(0, 2) == 0, int'($urandom_range(0, CH - 1)), rand_sample(), 0);
    apply(1, 2, rand_sample(), 0);
    apply(1, 4, rand_sample(), 0);
    do_reset();
    for (int i = 0; i < 8; i++) apply(1, 2, rand_sample(), 2);

    repeat (10) apply(0, 0, 0, 0);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mean_removal_multichannel.md
Name: mean_removal_multichannel

Overview:
- Time-multiplexed, multi-channel moving-average DC remover for the ADS1299 acquisition path.
- Sits between the ADC frame deserialiser and the SSVEP filtering/lock-in chain.
- Keeps an independent M-sample sliding window per channel and emits the channel's input, its mean removed, or the mean itself.
- Fully pipelined: 3-cycle fixed latency, accepts a sample every clock, adds per-channel warm-up tracking, saturation and synchronous clear.

Parameters:
- W, 24, signed sample width in and out.
- CH, 8, number of channels; range 1..16.
- LOG2_M, 5, window depth M = 2^LOG2_M; range 1..10.
- SUPPRESS_WARMUP, 0, 1 = no data_out_valid for a channel until its window is full.
- CW, derived = max(1,$clog2(CH)), channel tag width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of all channel state.
- mode  in  2  00 bypass, 01 remove mean, 10 output mean, 11 = bypass.
- data_in  in  W  signed sample.
- data_in_channel  in  CW  channel tag of data_in; values >= CH are ignored.
- data_in_valid  in  1  sample strobe, any duty cycle.
- data_out  out  W  signed result.
- data_out_channel  out  CW  tag of data_out.
- data_out_valid  out  1  one-cycle strobe per result.
- window_full  out  1  the output's channel had >= M samples at that time.

Behaviour:
- Reset (async, active-low):
  - data_out=0, data_out_channel=0, data_out_valid=0, window_full=0.
  - All accumulators, write pointers, fill counters and pipeline valid bits = 0.
  - Sample memory is not cleared.
- Per-channel state:
  - Circular memory CH×M×W.
  - Write pointer, LOG2_M bits, wraps M-1 -> 0.
  - Fill counter, saturates at M.
  - Accumulator, ACC = W+LOG2_M bits, signed.
- Stage 1 (cycle of data_in_valid):
  - Capture sample, channel and mode.
  - Read old = mem[ch][ptr[ch]]; write the new sample at the same address (read-before-write).
  - ptr[ch]++; fill[ch]++ if < M.
  - The "full" flag carried down the pipe is the fill value before the increment == M.
- Stage 2:
  - Outgoing term = old if full else 0. This removes any need to clear memory.
  - acc[ch] <= acc[ch] + sample - outgoing.
  - The new accumulator value and the sample travel down the pipe.
- Stage 3:
  - mean = acc_new >>> LOG2_M (arithmetic shift, floor toward -inf).
  - Result per captured mode:
    - bypass -> sample.
    - remove mean -> sat_W(sample - mean), computed at W+1 bits, clamped to [-2^(W-1), 2^(W-1)-1].
    - mean -> mean.
  - window_full = 1 when fill reached M after including this sample.
  - data_out_valid = 1 unless SUPPRESS_WARMUP=1 and window_full=0.
- Latency: exactly 3 clocks from data_in_valid to data_out_valid. The pipeline advances every clock, valid bits included.
- Outputs hold their last value when data_out_valid=0.
- Back-to-back samples on the same channel on consecutive clocks must be exact. The accumulator is read and written within stage 2 only; no stall, no forwarding error allowed.
- Before the window is full, mean = partial sum / M, i.e. a zero-padded window.
- clear=1:
  - Next clock: all acc, ptr and fill are zeroed.
  - All stage 1–3 valid bits are cleared, so in-flight results are dropped.
  - A data_in_valid in the same cycle is discarded.
  - data_out and data_out_channel hold their last value.
- Out-of-range channel tag: the sample is dropped with no state change and no output.
- Mode is latched per sample. A change of mode affects only samples accepted after it.
- Reset asserted mid-stream aborts all in-flight results immediately.

Test Plan:
- Single-channel step:
  - Stimulus: CH=8, LOG2_M=5, mode=01; ch0 gets 32 samples of 1000.
  - Required: output k (1-based) = 1000 - floor(1000·k/32); output 32 = 0 with window_full=1; later outputs = 0.
- Interleaved channels:
  - Stimulus: round-robin ch0..7, ch n constant 100·n−400, valid every clock, mode=10.
  - Required: each channel's mean reaches its own constant after its 32nd sample; data_out_channel matches the input tag delayed 3 clocks.
- Back-to-back same channel:
  - Stimulus: ch3 gets 64 consecutive clocks of ramp 0..63, mode=10.
  - Required: outputs from the 32nd sample onward = floor(mean of last 32), e.g. last output = 47.
- Saturation:
  - Stimulus: W=24; window filled with -8388608; then one sample +8388607, mode=01.
  - Required: data_out = 8388607 (clamped).
- Clear and warm-up suppression:
  - Stimulus: SUPPRESS_WARMUP=1; ch1 filled to window_full; pulse clear while 2 samples are in flight.
  - Required: those 2 outputs never appear; next 31 ch1 samples produce no valid; the 32nd produces valid with window_full=1.
- Bypass, gaps and reset:
  - Stimulus: mode=00, sparse valids, then reset low mid-stream.
  - Required: data_out = data_in exactly 3 clocks later; after reset, data_out_valid=0 and window_full=0 immediately, and means restart from 0.
